vga_rx_monitor: RTL
===================

VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 SHALL have parameter H_ACT, default 640: required active pixels per line.
REQ-002 SHALL have parameter V_ACT, default 480: required active lines per frame.
REQ-003 SHALL have parameter CW, default 12: width of the coordinate and measurement counters.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pix_en  in  1  pixel-rate sample strobe.
REQ-007 SHALL have port hs  in  1  horizontal sync, active-low.
REQ-008 SHALL have port vs  in  1  vertical sync, active-low.
REQ-009 SHALL have port blank  in  1  1 = active video, 0 = blanking.
REQ-010 SHALL have ports R, G, B  in  8 each  pixel colour.
REQ-011 SHALL have port px_valid  out  1  captured-pixel strobe.
REQ-012 SHALL have ports px_x, px_y  out  CW each  captured-pixel coordinates.
REQ-013 SHALL have port px_rgb  out  24  captured pixel as {R,G,B}.
REQ-014 SHALL have port frame_done  out  1  one-cycle end-of-frame pulse.
REQ-015 SHALL have port locked  out  1  timing lock indicator.
REQ-016 SHALL have port err  out  1  sticky timing error.
REQ-017 SHALL have ports meas_w, meas_h  out  CW each  last measured line width and frame height.
REQ-018 SHALL have port checksum  out  16  last frame colour checksum.

Function
REQ-019 SHALL sample inputs and change state only on clk edges with pix_en=1; with pix_en=0, state SHALL hold and px_valid SHALL be 0.
REQ-020 SHALL detect edges by comparing current samples against the previous pix_en sample.
REQ-021 SHALL use states SEARCH and FRAME; after reset SHALL be in SEARCH; SEARCH SHALL ignore all video and move to FRAME on a vs falling edge, clearing x, y and the line counter.
REQ-022 In FRAME, each sample with blank=1 SHALL be an active pixel; px_valid SHALL pulse one clk later with px_x=x, px_y=y and px_rgb={R,G,B}; x SHALL then increment.
REQ-023 On an hs falling edge, if the line held at least one active pixel: meas_w SHALL load x, y SHALL increment, and err SHALL set if x != H_ACT; x SHALL reset to 0 in all cases.
REQ-024 On a vs falling edge in FRAME: the frame SHALL close; meas_h SHALL load the active-line count; frame_done SHALL pulse one clk later; a new frame SHALL start immediately.
REQ-025 A frame SHALL be good iff every line width == H_ACT and line count == V_ACT.
REQ-026 The good-frame counter SHALL saturate at 2; locked SHALL be 1 while the counter equals 2.
REQ-027 A bad frame SHALL clear the counter and locked and SHALL set err.
REQ-028 If vs and hs falling edges coincide, the open line SHALL be closed first (counted if active), then the frame.
REQ-029 An active pixel while vs=0 SHALL set err and SHALL NOT raise px_valid.
REQ-030 x and y SHALL saturate at 2^CW-1 and SHALL set err on saturation.
REQ-031 err SHALL be cleared only by reset.

Reset
REQ-032 Asserting rst=0 SHALL at once force SEARCH, clear all counters, and drive px_valid, frame_done, locked, err, px_x, px_y, px_rgb, meas_w, meas_h and checksum to 0, including mid-frame.
REQ-033 After release, lock SHALL require two new good frames.

Configuration
REQ-034 With macro VGA_RX_CHECKSUM_EN defined, the 16-bit sum mod 2^16 of R+G+B over all active pixels of a frame SHALL be accumulated, SHALL clear at frame start, and SHALL be loaded into checksum with frame_done.
REQ-035 Without VGA_RX_CHECKSUM_EN, no accumulator SHALL be built and checksum SHALL be constant 0.

Verification (H_ACT=4, V_ACT=3, pix_en=1)
REQ-036 Two clean 4x3 frames -> px_valid 12 times per frame, last at (3,2); meas_w=4, meas_h=3; locked=1 at the 2nd frame_done; err=0.
REQ-037 Third frame has line 1 with 5 pixels -> err=1 at that hs edge, locked=0 at frame_done, meas_w=5.
REQ-038 Checksum build, all pixels R=G=B=1 -> checksum=36 at frame_done; non-checksum build -> checksum stays 0.
REQ-039 rst=0 asserted mid-line of a locked stream -> all outputs 0 immediately; locked=1 again only after two further clean frames.
REQ-040 vs and hs falling in the same sample after the 3rd active line -> meas_h=3, frame good, no err.
REQ-041 pix_en toggling 1/0 with the clean stream held over pix_en=0 cycles -> results identical to REQ-036, px_valid never during pix_en=0 hold cycles.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// -----------------------------------------------------------------------------
// vga_rx_monitor
//
// Passive monitor for a VGA-style pixel stream. It captures every active pixel
// with its coordinates, measures line width and frame height, tracks timing
// lock over consecutive good frames and raises a sticky error on any timing
// violation.
//
// Optional feature (compile-time macro):
//   VGA_RX_CHECKSUM_EN - build a per-frame 16-bit colour checksum
//                        (sum of R+G+B over all active pixels, mod 2^16).
//                        When undefined, no accumulator exists and checksum
//                        is tied to 0.
//
// Parameters:
//   H_ACT - required active pixels per line
//   V_ACT - required active lines per frame
//   CW    - width of coordinate and measurement counters
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous reset, active-low
//   pix_en     in   pixel-rate sample strobe; nothing changes while low
//   hs, vs     in   horizontal / vertical sync, active-low
//   blank      in   1 = active video, 0 = blanking
//   R, G, B    in   pixel colour, 8 bits each
//   px_valid   out  one-cycle strobe for a captured pixel
//   px_x, px_y out  coordinates of the captured pixel
//   px_rgb     out  captured pixel as {R,G,B}
//   frame_done out  one-cycle end-of-frame pulse
//   locked     out  high while the last two closed frames were both good
//   err        out  sticky timing error, cleared only by reset
//   meas_w     out  width of the last closed non-empty line
//   meas_h     out  active-line count of the last closed frame
//   checksum   out  colour checksum of the last closed frame
// -----------------------------------------------------------------------------
module vga_rx_monitor #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int CW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    input  logic          hs,
    input  logic          vs,
    input  logic          blank,
    input  logic [7:0]    R,
    input  logic [7:0]    G,
    input  logic [7:0]    B,
    output logic          px_valid,
    output logic [CW-1:0] px_x,
    output logic [CW-1:0] px_y,
    output logic [23:0]   px_rgb,
    output logic          frame_done,
    output logic          locked,
    output logic          err,
    output logic [CW-1:0] meas_w,
    output logic [CW-1:0] meas_h,
    output logic [15:0]   checksum
);

    typedef enum logic {
        SEARCH,
        FRAME
    } state_t;

    localparam logic [CW-1:0] XY_MAX  = '1;
    localparam logic [CW-1:0] XY_ONE  = CW'(1);
    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACT);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACT);

    state_t        state;
    state_t        state_next;

    // Sync levels from the previous pix_en sample; edges are found against these.
    logic          hs_q;
    logic          vs_q;

    logic [CW-1:0] x;          // pixel index within the open line
    logic [CW-1:0] y;          // active lines closed so far in this frame
    logic          frame_bad;  // a closed line of this frame had a wrong width
    logic [1:0]    good_cnt;   // consecutive good frames, saturating at 2

    // Per-sample decode
    logic          hs_fall;
    logic          vs_fall;
    logic          in_frame;
    logic          pix_ok;
    logic          pix_bad;
    logic          line_close;
    logic          line_bad;
    logic          y_sat;
    logic [CW-1:0] y_closed;
    logic          frame_close;
    logic          frame_good;
    logic [CW-1:0] x_base;
    logic [CW-1:0] y_base;
    logic          x_sat;
    logic [CW-1:0] x_next;
    logic          err_set;

    // -------------------------------------------------------------------------
    // Next-state and per-sample decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a value before any branch so no latch is inferred.
        state_next = state;

        hs_fall  = pix_en & hs_q & ~hs;
        vs_fall  = pix_en & vs_q & ~vs;
        in_frame = (state == FRAME);

        // A pixel sampled while vs is low is a timing error, not a capture.
        pix_ok  = pix_en & in_frame & blank & vs;
        pix_bad = pix_en & in_frame & blank & ~vs;

        // An hs edge closes the line only if it actually carried pixels.
        line_close = in_frame & hs_fall & (x != '0);
        line_bad   = line_close & (x != H_ACT_C);
        y_sat      = line_close & (y == XY_MAX);
        y_closed   = (line_close && !y_sat) ? y + XY_ONE : y;

        // When hs and vs fall together the line above is already folded into
        // y_closed and line_bad, so the frame sees it before it closes.
        frame_close = in_frame & vs_fall;
        frame_good  = !(frame_bad | line_bad) && (y_closed == V_ACT_C);

        // Sync edges are processed first; an active pixel in the same sample
        // belongs to the line/frame that the edge just opened.
        x_base = (hs_fall | vs_fall) ? '0 : x;
        y_base = vs_fall ? '0 : y_closed;
        x_sat  = pix_ok & (x_base == XY_MAX);
        x_next = (pix_ok && !x_sat) ? x_base + XY_ONE : x_base;

        err_set = pix_bad | x_sat | y_sat | line_bad | (frame_close & ~frame_good);

        if (state == SEARCH && vs_fall) begin
            state_next = FRAME;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEARCH;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register sees the pre-edge values of the others.
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Counters, measurements and sync history
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q      <= 1'b1;   // idle sync level, so release never fakes an edge
            vs_q      <= 1'b1;
            x         <= '0;
            y         <= '0;
            frame_bad <= 1'b0;
            good_cnt  <= 2'd0;
            meas_w    <= '0;
            meas_h    <= '0;
            err       <= 1'b0;
        end else if (pix_en) begin
            hs_q <= hs;
            vs_q <= vs;
            x    <= x_next;
            y    <= y_base;

            if (vs_fall) begin
                frame_bad <= 1'b0;
            end else if (line_bad) begin
                frame_bad <= 1'b1;
            end

            if (line_close) begin
                meas_w <= x;
            end

            if (frame_close) begin
                meas_h <= y_closed;
                if (frame_good) begin
                    good_cnt <= (good_cnt == 2'd2) ? 2'd2 : good_cnt + 2'd1;
                end else begin
                    good_cnt <= 2'd0;
                end
            end

            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output strobes and captured pixel. The strobes are recomputed on every
    // clk so they last exactly one cycle and stay low after a pix_en=0 edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            px_valid   <= 1'b0;
            frame_done <= 1'b0;
            px_x       <= '0;
            px_y       <= '0;
            px_rgb     <= '0;
        end else begin
            px_valid   <= pix_ok;
            frame_done <= frame_close;
            if (pix_ok) begin
                px_x   <= x_base;
                px_y   <= y_base;
                px_rgb <= {R, G, B};
            end
        end
    end

    assign locked = (good_cnt == 2'd2);

    // -------------------------------------------------------------------------
    // Optional colour checksum
    // -------------------------------------------------------------------------
`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] acc;
    logic [15:0] pix_sum;

    always_comb begin
        pix_sum = 16'(R) + 16'(G) + 16'(B);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            checksum <= '0;
        end else if (pix_en) begin
            // A closing vs edge never carries a pixel (vs is low), so the
            // accumulator is complete when it is handed to checksum.
            if (vs_fall) begin
                acc <= '0;
            end else if (pix_ok) begin
                acc <= acc + pix_sum;
            end
            if (frame_close) begin
                checksum <= acc;
            end
        end
    end
`else
    assign checksum = '0;
`endif

endmodule
